// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the UART receive controller and the surrounding
// receiver: serial line, configuration, edge/bit counter handshake, results.
interface uart_rx_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  RX_IN;
  logic [5:0]            Prescale;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [5:0]            edge_cnt;
  logic [3:0]            bit_cnt;
  logic                  cnt_enable;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;
  logic                  busy;

  // slave: the receive controller itself
  modport slave (
    input  RX_IN, Prescale, PAR_EN, PAR_TYP, edge_cnt, bit_cnt,
    output cnt_enable, P_DATA, data_valid, par_err, stp_err, busy
  );

  // master: line driver, configuration source and edge/bit counter
  modport master (
    output RX_IN, Prescale, PAR_EN, PAR_TYP, edge_cnt, bit_cnt,
    input  cnt_enable, P_DATA, data_valid, par_err, stp_err, busy
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: frames start/data/parity/stop bits using an external
// edge/bit counter, majority-votes three mid-bit samples and flags errors.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input logic           CLK,
  input logic           RST,
  uart_rx_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state_reg;
  state_t                state_next;

  logic [5:0]            half;
  logic                  last_edge;
  logic [2:0]            samp_vec;
  logic                  voted;
  logic                  active;
  logic                  par_expect;

  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] pdata_reg;
  logic                  dv_reg;
  logic                  par_err_reg;
  logic                  stp_err_reg;
  logic                  par_en_reg;
  logic                  par_typ_reg;

  assign half      = bus.Prescale >> 1;
  assign last_edge = (bus.edge_cnt == (bus.Prescale - 6'd1));

  // Three taps straddling mid-bit: half-1, half, half+1.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_samp
      logic [5:0] tap;
      logic       samp_reg;

      assign tap = half + 6'(gi) - 6'd1;

      always_ff @(posedge CLK) begin
        if (!RST) begin
          samp_reg <= 1'b1;
        end else if ((state_reg != IDLE) && (bus.edge_cnt == tap)) begin
          samp_reg <= bus.RX_IN;
        end
      end

      assign samp_vec[gi] = samp_reg;
    end
  endgenerate

  assign voted = (samp_vec[0] & samp_vec[1]) |
                 (samp_vec[0] & samp_vec[2]) |
                 (samp_vec[1] & samp_vec[2]);

  assign par_expect = (^shift_reg) ^ par_typ_reg;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    active     = (state_reg != IDLE);
    case (state_reg)
      IDLE: begin
        if (!bus.RX_IN) begin
          state_next = START;
        end
      end
      START: begin
        if (last_edge) begin
          state_next = voted ? IDLE : DATA;
        end
      end
      DATA: begin
        if (last_edge && (bus.bit_cnt == 4'(DATA_WIDTH))) begin
          state_next = par_en_reg ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (last_edge) begin
          state_next = STOP;
        end
      end
      STOP: begin
        if (last_edge) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      shift_reg   <= '0;
      pdata_reg   <= '0;
      dv_reg      <= 1'b0;
      par_err_reg <= 1'b0;
      stp_err_reg <= 1'b0;
      par_en_reg  <= 1'b0;
      par_typ_reg <= 1'b0;
    end else begin
      dv_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // Parity configuration is frozen for the whole frame from here on.
          if (!bus.RX_IN) begin
            par_en_reg  <= bus.PAR_EN;
            par_typ_reg <= bus.PAR_TYP;
            par_err_reg <= 1'b0;
            stp_err_reg <= 1'b0;
          end
        end
        DATA: begin
          if (last_edge) begin
            shift_reg <= {voted, shift_reg[DATA_WIDTH-1:1]};
          end
        end
        PARITY: begin
          if (last_edge) begin
            par_err_reg <= (voted != par_expect);
          end
        end
        STOP: begin
          if (last_edge) begin
            stp_err_reg <= ~voted;
            if (voted && !par_err_reg) begin
              pdata_reg <= shift_reg;
              dv_reg    <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.cnt_enable = active;
  assign bus.busy       = active;
  assign bus.P_DATA     = pdata_reg;
  assign bus.data_valid = dv_reg;
  assign bus.par_err    = par_err_reg;
  assign bus.stp_err    = stp_err_reg;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: models the edge/bit counter, drives
// directed and random frames, and predicts results from frame-level rules.
module tb_uart_rx_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  uart_rx_ctrl_if #(.DATA_WIDTH(W)) bus ();

  uart_rx_ctrl #(.DATA_WIDTH(W)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Edge/bit counter that the controller expects next to it.
  always @(posedge clk) begin
    if (!rst || !bus.cnt_enable) begin
      bus.edge_cnt <= 6'd0;
      bus.bit_cnt  <= 4'd0;
    end else if (bus.edge_cnt == bus.Prescale - 6'd1) begin
      bus.edge_cnt <= 6'd0;
      bus.bit_cnt  <= bus.bit_cnt + 4'd1;
    end else begin
      bus.edge_cnt <= bus.edge_cnt + 6'd1;
    end
  end

  int strobes     = 0;
  int last_strobe = -1;
  always @(negedge clk) begin
    if (bus.data_valid === 1'b1) begin
      strobes++;
      last_strobe = cyc;
    end
  end

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_pdata = 8'h00;
  int         exp_strobes = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic good_parity(input logic [7:0] data, input logic typ);
    // Even: total ones incl. parity bit even; odd: total ones odd.
    good_parity = ($countones(data) % 2 == 1) ? ~typ : typ;
  endfunction

  task automatic drive_bit(input logic b, input int p, input bit glitch);
    int gk;
    gk = glitch ? (p / 2 - 1 + int'($urandom_range(0, 2))) : -1;
    for (int k = 0; k < p; k++) begin
      bus.RX_IN = (k == gk) ? ~b : b;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input bit pen, input bit ptyp,
                            input logic par_bit, input logic stop_bit, input int p,
                            input bit immediate, input bit glitch, input bit scramble,
                            output int t0);
    bus.Prescale = 6'(p);
    bus.PAR_EN   = pen;
    bus.PAR_TYP  = ptyp;
    if (!immediate) begin
      @(posedge clk);
      #1;
    end
    bus.RX_IN = 1'b0;
    @(posedge clk);
    #1;
    t0 = cyc;
    if (scramble) begin
      bus.PAR_EN  = 1'($urandom);
      bus.PAR_TYP = 1'($urandom);
    end
    drive_bit(1'b0, p, glitch);
    for (int i = 0; i < 8; i++) drive_bit(data[i], p, glitch);
    if (pen) drive_bit(par_bit, p, glitch);
    drive_bit(stop_bit, p, glitch);
    bus.RX_IN = 1'b1;
  endtask

  task automatic check_frame(input string tag, input logic [7:0] data, input bit pen,
                             input bit ptyp, input logic par_bit, input logic stop_bit,
                             input int p, input int t0);
    bit pe, se, ok;
    int n;
    pe = pen && ((($countones(data) + int'(par_bit)) % 2) != (ptyp ? 1 : 0));
    se = (stop_bit == 1'b0);
    ok = !pe && !se;
    n  = pen ? 11 : 10;
    @(negedge clk);
    #1;
    chk({tag, "_dv"}, 32'(bus.data_valid), 32'(ok));
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_par_err"}, 32'(bus.par_err), 32'(pe));
    chk({tag, "_stp_err"}, 32'(bus.stp_err), 32'(se));
    if (ok) begin
      exp_pdata = data;
      exp_strobes++;
      chk({tag, "_latency"}, 32'(last_strobe - t0), 32'(n * p));
    end
    chk({tag, "_pdata"}, 32'(bus.P_DATA), 32'(exp_pdata));
  endtask

  initial begin
    int   t0;
    int   s1;
    int   p;
    logic [7:0] d;
    bit   pen, ptyp, glitch, scramble, imm;
    logic pb, sb;

    bus.RX_IN    = 1'b1;
    bus.Prescale = 6'd8;
    bus.PAR_EN   = 1'b0;
    bus.PAR_TYP  = 1'b0;
    rst          = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_cnt_en", 32'(bus.cnt_enable), 32'd0);
    chk("rst_pdata", 32'(bus.P_DATA), 32'd0);
    chk("rst_dv", 32'(bus.data_valid), 32'd0);
    chk("rst_par_err", 32'(bus.par_err), 32'd0);
    chk("rst_stp_err", 32'(bus.stp_err), 32'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Plain frame, no parity.
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8, 1'b0, 1'b0, 1'b0, t0);
    check_frame("f_a5", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8, t0);
    $display("frame A5 p8 noparity checked at cycle %0d", cyc);

    // Wrong parity first (P_DATA must keep A5), then correct parity.
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 16, 1'b0, 1'b0, 1'b0, t0);
    check_frame("f_3c_bad", 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 16, t0);
    $display("frame 3C p16 bad parity checked at cycle %0d", cyc);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 16, 1'b0, 1'b0, 1'b0, t0);
    check_frame("f_3c_good", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 16, t0);
    $display("frame 3C p16 good parity checked at cycle %0d", cyc);

    // Start-bit glitch: low for two cycles only.
    bus.Prescale = 6'd8;
    @(posedge clk);
    #1;
    bus.RX_IN = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    bus.RX_IN = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("glitch_busy_before", 32'(bus.busy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("glitch_busy_after", 32'(bus.busy), 32'd0);
    chk("glitch_dv", 32'(bus.data_valid), 32'd0);
    chk("glitch_par_err", 32'(bus.par_err), 32'd0);
    chk("glitch_stp_err", 32'(bus.stp_err), 32'd0);
    $display("start glitch checked at cycle %0d", cyc);

    // Stop-bit error.
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 32, 1'b0, 1'b0, 1'b0, t0);
    check_frame("f_81_stop", 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 32, t0);
    $display("frame 81 p32 stop error checked at cycle %0d", cyc);

    // Back-to-back frames with a single idle cycle.
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 8, 1'b0, 1'b0, 1'b0, t0);
    check_frame("b2b_55", 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 8, t0);
    s1 = last_strobe;
    send_frame(8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 8, 1'b1, 1'b0, 1'b0, t0);
    check_frame("b2b_aa", 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 8, t0);
    chk("b2b_gap", 32'(last_strobe - s1), 32'd81);
    $display("back-to-back 55/AA checked, gap %0d", last_strobe - s1);

    // Reset in the middle of the data bits.
    bus.Prescale = 6'd8;
    bus.PAR_EN   = 1'b0;
    @(posedge clk);
    #1;
    bus.RX_IN = 1'b0;
    @(posedge clk);
    #1;
    drive_bit(1'b0, 8, 1'b0);
    drive_bit(1'b1, 8, 1'b0);
    drive_bit(1'b1, 8, 1'b0);
    chk("mid_rst_busy_before", 32'(bus.busy), 32'd1);
    rst       = 1'b0;
    bus.RX_IN = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b1;
    exp_pdata = 8'h00;
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_cnt_en", 32'(bus.cnt_enable), 32'd0);
    chk("mid_rst_pdata", 32'(bus.P_DATA), 32'd0);
    chk("mid_rst_dv", 32'(bus.data_valid), 32'd0);
    chk("mid_rst_errs", 32'({bus.par_err, bus.stp_err}), 32'd0);
    repeat (100) @(posedge clk);
    #1;
    chk("mid_rst_no_strobe", 32'(strobes), 32'(exp_strobes));
    send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 8, 1'b0, 1'b0, 1'b0, t0);
    check_frame("after_rst_12", 8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 8, t0);
    $display("mid-frame reset then 12 checked at cycle %0d", cyc);

    // Random frames: sample glitches, config changes while busy, injected errors.
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 2))
        0:       p = 8;
        1:       p = 16;
        default: p = 32;
      endcase
      d        = 8'($urandom);
      pen      = 1'($urandom);
      ptyp     = 1'($urandom);
      pb       = good_parity(d, ptyp) ^ ($urandom_range(0, 3) == 0);
      sb       = ($urandom_range(0, 9) != 0);
      glitch   = 1'($urandom);
      scramble = 1'($urandom);
      imm      = ($urandom_range(0, 2) == 0);
      send_frame(d, pen, ptyp, pb, sb, p, imm, glitch, scramble, t0);
      check_frame("rand", d, pen, ptyp, pb, sb, p, t0);
      $display("rand frame %0d data=%02h p=%0d pen=%0d typ=%0d pbit=%0d stop=%0d", i, d, p, pen, ptyp, pb, sb);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("strobe_total", 32'(strobes), 32'(exp_strobes));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
